ram_seq_ctrl: RTL

//   Parametrised single-port RAM with a command FSM in front of it. Supports single read/write,
//   a FILL sweep (write one value to every address) and a SCAN sweep (stream every word out).

---
 rtl/ram_seq_pkg.sv | 22 ++
 rtl/ram_sp.sv | 29 ++
 rtl/ram_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ram_seq_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ram_seq_pkg
// Description : Command opcodes and FSM state encodings for ram_seq_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
package ram_seq_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_SCAN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_FILL = 2'd2,
        ST_SCAN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_sp.sv
`default_nettype none
//==============================================================================
// Module      : ram_sp
// Description : Single-port RAM, synchronous write, registered read (old data
//               on a same-address read-during-write). Contents are not reset.
// Revision    : 1.0 - initial release
//==============================================================================
module ram_sp #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_q <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/ram_seq_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : ram_seq_ctrl
// Description : Command FSM in front of a single-port RAM: READ, WRITE, FILL
//               (write one value everywhere) and SCAN (stream every word out).
// Revision    : 1.0 - initial release
//==============================================================================
module ram_seq_ctrl
    import ram_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cmd_ready,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done
);

    localparam int                DEPTH       = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_one       = ADDR_W'(1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ctr, w_ctr_nxt;
    logic [DATA_W-1:0] r_fill, w_fill_nxt;
    logic [ADDR_W-1:0] r_addr_lat, w_addr_lat_nxt;
    logic              r_cmd_ready, r_busy;
    logic              r_rd_valid, w_rd_valid_nxt;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
    logic [DATA_W-1:0] r_rd_data, w_rd_data_nxt;
    logic              r_done, w_done_nxt;

    logic              w_accept;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_q;

    assign w_accept = cmd_valid && r_cmd_ready;

    ram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_q     (w_ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ctr       <= '0;
            r_fill      <= '0;
            r_addr_lat  <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ctr       <= w_ctr_nxt;
            r_fill      <= w_fill_nxt;
            r_addr_lat  <= w_addr_lat_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_rd_valid  <= w_rd_valid_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ctr_nxt      = r_ctr;
        w_fill_nxt     = r_fill;
        w_addr_lat_nxt = r_addr_lat;
        w_rd_valid_nxt = 1'b0;
        w_rd_addr_nxt  = r_rd_addr;
        w_rd_data_nxt  = r_rd_data;
        w_done_nxt     = 1'b0;
        w_ram_we       = 1'b0;
        w_ram_addr     = r_addr_lat;
        w_ram_wdata    = r_fill;

        case (r_state)
            ST_IDLE: begin
                // A SCAN prefetches word 0 so its first beat lands one edge after accept.
                w_ram_addr  = (cmd_op == OP_SCAN) ? '0 : cmd_addr;
                w_ram_wdata = cmd_data;
                if (w_accept) begin
                    case (cmd_op)
                        OP_READ: begin
                            w_addr_lat_nxt = cmd_addr;
                            w_state_nxt    = ST_READ;
                        end
                        OP_WRITE: begin
                            w_ram_we   = 1'b1;
                            w_done_nxt = 1'b1;
                        end
                        OP_FILL: begin
                            w_fill_nxt  = cmd_data;
                            w_ctr_nxt   = '0;
                            w_state_nxt = ST_FILL;
                        end
                        default: begin
                            w_ctr_nxt   = '0;
                            w_state_nxt = ST_SCAN;
                        end
                    endcase
                end
            end
            ST_READ: begin
                w_rd_valid_nxt = 1'b1;
                w_rd_addr_nxt  = r_addr_lat;
                w_rd_data_nxt  = w_ram_q;
                w_done_nxt     = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            ST_FILL: begin
                w_ram_we   = 1'b1;
                w_ram_addr = r_ctr;
                w_ctr_nxt  = r_ctr + c_one;
                if (r_ctr == c_last_addr) begin
                    w_ctr_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                // RAM is read one word ahead of the beat being presented.
                w_ram_addr     = r_ctr + c_one;
                w_rd_valid_nxt = 1'b1;
                w_rd_addr_nxt  = r_ctr;
                w_rd_data_nxt  = w_ram_q;
                w_ctr_nxt      = r_ctr + c_one;
                if (r_ctr == c_last_addr) begin
                    w_ctr_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign rd_valid  = r_rd_valid;
    assign rd_addr   = r_rd_addr;
    assign rd_data   = r_rd_data;
    assign done      = r_done;

endmodule
`default_nettype wire
